weight_row_loader: RTL and testbench

- Sits directly downstream of the weight buffer and upstream of the weight-stationary PE array.
- Captures the flat weight vector once the weight buffer reports full, then streams it into the PE array one kernel row per handshake.
- Flags when the array holds a complete, stable weight set.
- Supports reloading a new weight set on command.

---
 rtl/npu_pkg.sv | 22 ++
 rtl/weight_row_mux.sv | 24 ++
 rtl/weight_row_loader.sv | 143 ++++++++++++++
 tb/tb_weight_row_loader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU weight path.
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } loader_state_t;

    localparam int LDR_WIDTH = 4;
    localparam int LDR_KH    = 3;
    localparam int LDR_KW    = 3;
    localparam int ROW_BITS  = LDR_WIDTH * LDR_KW;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/weight_row_mux.sv
// Combinational selection of one kernel row from a flat weight vector.
module weight_row_mux
    import npu_pkg::*;
#(
    parameter int WIDTH = LDR_WIDTH,
    parameter int KH    = LDR_KH,
    parameter int KW    = LDR_KW,
    parameter int SW    = clog2_min1(LDR_KH)
) (
    input  logic [WIDTH*KH*KW-1:0] vec_i,
    input  logic [SW-1:0]          sel_i,
    output logic [WIDTH*KW-1:0]    row_o
);

    localparam int RB = WIDTH * KW;

    always_comb begin
        row_o = '0;
        for (int r = 0; r < KH; r++) begin
            if (sel_i == SW'(r)) row_o = vec_i[r*RB +: RB];
        end
    end

endmodule

// File: rtl/weight_row_loader.sv
// Streams a captured weight set into the PE array one kernel row per handshake.
// Optional running checksum output under WEIGHT_ROW_LOADER_CHECKSUM_EN.
module weight_row_loader
    import npu_pkg::*;
#(
    parameter int WIDTH         = LDR_WIDTH,
    parameter int WEIGHT_HEIGHT = LDR_KH,
    parameter int WEIGHT_WIDTH  = LDR_KW
) (
    input  logic clk,
    input  logic reset,
    input  logic [WIDTH*WEIGHT_HEIGHT*WEIGHT_WIDTH-1:0] weights,
    input  logic weight_buffer_ready,
    input  logic reload,
    input  logic row_ready,
    output logic row_valid,
    output logic [WIDTH*WEIGHT_WIDTH-1:0] row_data,
    output logic [clog2_min1(WEIGHT_HEIGHT)-1:0] row_idx,
`ifdef WEIGHT_ROW_LOADER_CHECKSUM_EN
    output logic [WIDTH+7:0] weight_checksum,
`endif
    output logic weights_loaded,
    output logic load_done
);

    localparam int KH = WEIGHT_HEIGHT;
    localparam int KW = WEIGHT_WIDTH;
    localparam int RB = WIDTH * KW;
    localparam int VB = RB * KH;
    localparam int SW = clog2_min1(KH);
    localparam logic [SW-1:0] LAST = SW'(KH - 1);

    loader_state_t state_q;
    logic          armed_q;
    logic          row_valid_q;
    logic [RB-1:0] row_data_q;
    logic [SW-1:0] row_idx_q;
    logic          loaded_q;
    logic [VB-1:0] shadow_q;

    logic [VB-1:0] src_d;
    logic [SW-1:0] sel_d;
    logic [RB-1:0] row_d;
    logic          xfer;
    logic          capture;

    // In IDLE the first row comes straight from the input so it is ready
    // one cycle after capture; afterwards the mux looks one row ahead.
    assign src_d   = (state_q == IDLE) ? weights : shadow_q;
    assign sel_d   = (state_q == IDLE) ? '0 : row_idx_q + 1'b1;
    assign xfer    = row_valid_q && row_ready;
    assign capture = (state_q == IDLE) && armed_q && weight_buffer_ready;

    weight_row_mux #(
        .WIDTH(WIDTH),
        .KH   (KH),
        .KW   (KW),
        .SW   (SW)
    ) u_mux (
        .vec_i(src_d),
        .sel_i(sel_d),
        .row_o(row_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            armed_q     <= 1'b1;
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            row_idx_q   <= '0;
            loaded_q    <= 1'b0;
            shadow_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (reload) armed_q <= 1'b1;
                    if (capture) begin
                        shadow_q    <= weights;
                        armed_q     <= 1'b0;
                        row_idx_q   <= '0;
                        row_data_q  <= row_d;
                        row_valid_q <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (row_idx_q == LAST) begin
                            row_valid_q <= 1'b0;
                            row_data_q  <= '0;
                            loaded_q    <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            row_idx_q  <= row_idx_q + 1'b1;
                            row_data_q <= row_d;
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        loaded_q <= 1'b0;
                        armed_q  <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign row_valid      = row_valid_q;
    assign row_data       = row_data_q;
    assign row_idx        = row_idx_q;
    assign weights_loaded = loaded_q;
    assign load_done      = xfer && (row_idx_q == LAST);

`ifdef WEIGHT_ROW_LOADER_CHECKSUM_EN
    localparam int CW = WIDTH + 8;

    logic [CW-1:0] csum_q;
    logic [CW-1:0] row_sum_d;

    always_comb begin
        row_sum_d = '0;
        for (int k = 0; k < KW; k++) begin
            row_sum_d = row_sum_d + CW'(row_data_q[k*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || capture) begin
            csum_q <= '0;
        end else if (xfer) begin
            csum_q <= csum_q + row_sum_d;
        end
    end

    // Partial sums stay hidden until the whole set has been accepted.
    assign weight_checksum = loaded_q ? csum_q : '0;
`endif

endmodule

// File: tb/tb_weight_row_loader.sv
// Directed self-checking bench for weight_row_loader.
module tb_weight_row_loader;

    logic        clk;
    logic        reset;
    logic [35:0] weights;
    logic        weight_buffer_ready;
    logic        reload;
    logic        row_ready;
    logic        row_valid;
    logic [11:0] row_data;
    logic [1:0]  row_idx;
    logic        weights_loaded;
    logic        load_done;
`ifdef WEIGHT_ROW_LOADER_CHECKSUM_EN
    logic [11:0] weight_checksum;
`endif

    int checks;
    int failures;

    weight_row_loader dut (
        .clk                (clk),
        .reset              (reset),
        .weights            (weights),
        .weight_buffer_ready(weight_buffer_ready),
        .reload             (reload),
        .row_ready          (row_ready),
        .row_valid          (row_valid),
        .row_data           (row_data),
        .row_idx            (row_idx),
`ifdef WEIGHT_ROW_LOADER_CHECKSUM_EN
        .weight_checksum    (weight_checksum),
`endif
        .weights_loaded     (weights_loaded),
        .load_done          (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_row(input string tag, input logic [11:0] d,
                           input logic [1:0] idx, input logic done);
        chk({tag, "_valid"}, 64'(row_valid), 64'd1);
        chk({tag, "_data"}, 64'(row_data), 64'(d));
        chk({tag, "_idx"}, 64'(row_idx), 64'(idx));
        chk({tag, "_done"}, 64'(load_done), 64'(done));
    endtask

    task automatic exp_idle(input string tag, input logic loaded);
        chk({tag, "_valid"}, 64'(row_valid), 64'd0);
        chk({tag, "_loaded"}, 64'(weights_loaded), 64'(loaded));
        chk({tag, "_done"}, 64'(load_done), 64'd0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b1;
        weights = '0;
        weight_buffer_ready = 1'b0;
        reload = 1'b0;
        row_ready = 1'b0;
        step();
        step();
        exp_idle("rst", 1'b0);
        chk("rst_idx", 64'(row_idx), 64'd0);
        chk("rst_data", 64'(row_data), 64'd0);

        // basic load
        reset = 1'b0;
        weights = 36'h987654321;
        weight_buffer_ready = 1'b1;
        row_ready = 1'b1;
        exp_idle("pre_cap", 1'b0);
        step();
        exp_row("b_r0", 12'h321, 2'd0, 1'b0);
        step();
        exp_row("b_r1", 12'h654, 2'd1, 1'b0);
        step();
        exp_row("b_r2", 12'h987, 2'd2, 1'b1);
        step();
        exp_idle("b_done", 1'b1);
`ifdef WEIGHT_ROW_LOADER_CHECKSUM_EN
        chk("csum", 64'(weight_checksum), 64'h02D);
`endif

        // no re-capture without reload
        weights = 36'h111111111;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_idle("norecap", 1'b1);
        end
        pulse_reload();
        exp_idle("rl_idle", 1'b0);
        step();
        exp_row("n_r0", 12'h111, 2'd0, 1'b0);
`ifdef WEIGHT_ROW_LOADER_CHECKSUM_EN
        chk("csum_load", 64'(weight_checksum), 64'd0);
`endif
        weights = 36'h987654321;
        step();
        exp_row("n_r1", 12'h111, 2'd1, 1'b0);
        step();
        exp_row("n_r2", 12'h111, 2'd2, 1'b1);
        step();
        exp_idle("n_done", 1'b1);
`ifdef WEIGHT_ROW_LOADER_CHECKSUM_EN
        chk("csum_111", 64'(weight_checksum), 64'h009);
`endif

        // backpressure on row 1
        pulse_reload();
        step();
        exp_row("p_r0", 12'h321, 2'd0, 1'b0);
        step();
        row_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_row("p_hold", 12'h654, 2'd1, 1'b0);
            step();
        end
        row_ready = 1'b1;
        exp_row("p_r1", 12'h654, 2'd1, 1'b0);
        step();
        exp_row("p_r2", 12'h987, 2'd2, 1'b1);
        step();
        exp_idle("p_done", 1'b1);

        // reload ignored during LOAD
        pulse_reload();
        step();
        exp_row("i_r0", 12'h321, 2'd0, 1'b0);
        step();
        exp_row("i_r1", 12'h654, 2'd1, 1'b0);
        pulse_reload();
        exp_row("i_r2", 12'h987, 2'd2, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            exp_idle("i_done", 1'b1);
            step();
        end

        // reset mid-load
        pulse_reload();
        step();
        exp_row("r_r0", 12'h321, 2'd0, 1'b0);
        step();
        exp_row("r_r1", 12'h654, 2'd1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_idle("r_rst", 1'b0);
        chk("r_rst_idx", 64'(row_idx), 64'd0);
        step();
        exp_row("r2_r0", 12'h321, 2'd0, 1'b0);
        step();
        exp_row("r2_r1", 12'h654, 2'd1, 1'b0);
        step();
        exp_row("r2_r2", 12'h987, 2'd2, 1'b1);
        step();
        exp_idle("r2_done", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
